hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the RV32IM five-stage core. It watches the operands the instruction decode stage reads and the instruction held in EX, and generates the write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It detects load-use hazards, flushes the pipeline on taken branches and jumps, and sequences the multi-cycle M-extension divider through a start/done handshake with a timeout. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- DIV_TIMEOUT, 40: maximum number of cycles spent in DIV_BUSY before a forced exit; legal range 2..255.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- id_rs1, id_rs2  input  5 each  source register addresses (instruction[19:15], instruction[24:20]) in ID.
- id_use_rs1, id_use_rs2  input  1 each  ID instruction actually reads rs1 / rs2.
- ex_rd  input  5  destination register of the instruction in EX.
- ex_mem_read  input  1  EX instruction is a load.
- ex_div_op  input  1  EX instruction is DIV/DIVU/REM/REMU.
- branch_taken  input  1  EX resolved a taken branch or a jump (JAL/JALR).
- div_done  input  1  divider result is valid this cycle.
- pc_write_enable  output  1  PC loads its next value.
- if_id_write_enable, id_ex_write_enable  output  1 each  pipeline register loads.
- if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  register loads a NOP; flush overrides the write enable.
- div_start  output  1  one-cycle divider start pulse.
- div_busy  output  1  high while state is DIV_BUSY.
- div_error  output  1  sticky divider timeout flag.
- stall_cycles  output  32  saturating count of cycles with pc_write_enable=0.
- flush_count  output  16  saturating count of branch flushes.

## Operation
- States: RUN, DIV_BUSY. Reset value: RUN.
- Control outputs are combinational from the current state and inputs. Counters, state and div_error are registered.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Default, no event: pc_write_enable, if_id_write_enable and id_ex_write_enable are 1; all flushes are 0; div_start is 0.
- Event priority in RUN: branch_taken > ex_div_op > load_use.
- RUN, branch_taken: defaults plus if_id_flush=1 and id_ex_flush=1. flush_count increments. Stay in RUN.
- RUN, ex_div_op:
  - div_start=1; pc, IF/ID and ID/EX write enables are 0; ex_mem_flush=1.
  - Next state DIV_BUSY; timeout counter cleared to 0.
- RUN, load_use:
  - pc_write_enable=0 and if_id_write_enable=0; id_ex_flush=1 (one bubble). Stay in RUN.
  - The bubble clears ex_mem_read, so the hazard is not re-detected.
- DIV_BUSY, div_done=0 and counter < DIV_TIMEOUT-1: same freeze as the start cycle but div_start=0. Counter increments.
- DIV_BUSY, div_done=1: default (advance) outputs, so the quotient enters EX/MEM. Next state RUN.
- DIV_BUSY, div_done=0 and counter == DIV_TIMEOUT-1: default outputs and div_error set to 1. Next state RUN.
- div_error is sticky; only reset clears it.
- If div_done and timeout coincide, done wins and div_error stays 0.
- div_done while in RUN is ignored.
- In DIV_BUSY, branch_taken, load_use and ex_div_op are ignored, because EX is frozen.
- stall_cycles increments by 1 on each non-reset cycle with pc_write_enable=0 and saturates at 0xFFFFFFFF. flush_count saturates at 0xFFFF.

## Timing
- While reset=1:
  - pc_write_enable=0, if_id_write_enable=0, id_ex_write_enable=0.
  - if_id_flush=1, id_ex_flush=1, ex_mem_flush=1.
  - div_start=0, div_busy=0.
- On the reset edge: state goes to RUN, and div_error, stall_cycles, flush_count and the timeout counter go to 0.
- Reset during DIV_BUSY aborts the division immediately; no div_start and no div_error result.
- Load-use costs 1 stall cycle. A taken branch costs 2 flushed slots in the same cycle, with no stall.
- A division with div_done asserted N cycles after div_start (N ≥ 1) freezes the pipeline for N cycles, including the start cycle; the result advances on the div_done cycle.
- The longest DIV_BUSY residency is DIV_TIMEOUT cycles.
- Back-to-back divisions: the cycle after the div_done release, RUN sees the next ex_div_op and pulses div_start again.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc/IF-ID enables 0, id_ex_flush=1, stall_cycles 0->1; same stimulus with ex_rd=0 -> no stall.
- Branch vs. hazard: branch_taken=1 together with the load_use condition -> if_id_flush=id_ex_flush=1, pc_write_enable=1, flush_count 0->1, stall_cycles unchanged.
- Division: ex_div_op=1, div_done 5 cycles after div_start -> div_start high exactly 1 cycle, div_busy high 5 cycles, ex_mem_flush high 5 cycles, release on the done cycle, stall_cycles +5.
- Timeout: DIV_TIMEOUT=4, div_done never asserted -> 4 frozen cycles, then release, div_error=1 held until reset; div_done coinciding with the 4th cycle -> div_error=0.
- Reset mid-division: assert reset in the 2nd DIV_BUSY cycle -> next cycle state RUN, div_busy=0, counters 0, div_error 0.
- Saturation: preload or run flush_count to 0xFFFF, one more taken branch -> stays 0xFFFF.

Source files
------------

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stall, branch flush and divider sequencing for a 5-stage pipeline.
//   clk_i, reset_i                      clock and synchronous active-high reset
//   id_rs1_i/id_rs2_i, id_use_rs*_i     ID source registers and whether they are read
//   ex_rd_i, ex_mem_read_i, ex_div_op_i EX destination, load flag, divide flag
//   branch_taken_i                      EX resolved a taken branch/jump
//   div_done_i                          divider result valid
//   *_write_enable_o, *_flush_o         pipeline register controls (flush overrides enable)
//   div_start_o, div_busy_o, div_error_o divider handshake and sticky timeout flag
//   stall_cycles_o, flush_count_o       saturating performance counters
module hazard_controller #(
    parameter int DIV_TIMEOUT = 40
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_div_op_i,
    input  logic        branch_taken_i,
    input  logic        div_done_i,
    output logic        pc_write_enable_o,
    output logic        if_id_write_enable_o,
    output logic        id_ex_write_enable_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_flush_o,
    output logic        div_start_o,
    output logic        div_busy_o,
    output logic        div_error_o,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);
    typedef enum logic {RUN, DIV_BUSY} state_t;
    state_t      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        err_q, err_d;
    logic [31:0] stall_q;
    logic [15:0] flush_q;
    logic        flush_inc;
    logic        load_use;
    assign load_use = ex_mem_read_i & (ex_rd_i != 5'd0) &
                      ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) | (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    always_comb begin
        pc_write_enable_o    = 1'b1;
        if_id_write_enable_o = 1'b1;
        id_ex_write_enable_o = 1'b1;
        if_id_flush_o        = 1'b0;
        id_ex_flush_o        = 1'b0;
        ex_mem_flush_o       = 1'b0;
        div_start_o          = 1'b0;
        div_busy_o           = (state_q == DIV_BUSY);
        state_d              = state_q;
        tmo_d                = tmo_q;
        err_d                = err_q;
        flush_inc            = 1'b0;
        if (reset_i) begin
            pc_write_enable_o    = 1'b0;
            if_id_write_enable_o = 1'b0;
            id_ex_write_enable_o = 1'b0;
            if_id_flush_o        = 1'b1;
            id_ex_flush_o        = 1'b1;
            ex_mem_flush_o       = 1'b1;
            div_busy_o           = 1'b0;
        end else if (state_q == RUN) begin
            if (branch_taken_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                flush_inc     = 1'b1;
            end else if (ex_div_op_i) begin
                div_start_o          = 1'b1;
                pc_write_enable_o    = 1'b0;
                if_id_write_enable_o = 1'b0;
                id_ex_write_enable_o = 1'b0;
                ex_mem_flush_o       = 1'b1;
                state_d              = DIV_BUSY;
                tmo_d                = 8'd0;
            end else if (load_use) begin
                pc_write_enable_o    = 1'b0;
                if_id_write_enable_o = 1'b0;
                id_ex_flush_o        = 1'b1;
            end
        end else if (div_done_i) begin
            state_d = RUN;
        end else if (tmo_q == 8'(DIV_TIMEOUT - 1)) begin
            // Forced release: let the pipeline advance and flag the stuck divider.
            state_d = RUN;
            err_d   = 1'b1;
        end else begin
            pc_write_enable_o    = 1'b0;
            if_id_write_enable_o = 1'b0;
            id_ex_write_enable_o = 1'b0;
            ex_mem_flush_o       = 1'b1;
            tmo_d                = tmo_q + 8'd1;
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= RUN;
            tmo_q   <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= 32'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            stall_q <= (!pc_write_enable_o && stall_q != 32'hFFFF_FFFF) ? stall_q + 32'd1 : stall_q;
            flush_q <= (flush_inc && flush_q != 16'hFFFF) ? flush_q + 16'd1 : flush_q;
        end
    end
    assign div_error_o    = err_q;
    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench for hazard_controller with directed vectors.
module tb_hazard_controller;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0;
    logic id_use_rs1_i = 0, id_use_rs2_i = 0, ex_mem_read_i = 0, ex_div_op_i = 0;
    logic branch_taken_i = 0, div_done_i = 0;
    logic sel = 1'b0;

    logic [7:0]  ctl_a, ctl_b, obs_ctl;
    logic        err_a, err_b, obs_err;
    logic [31:0] st_a, st_b, obs_st;
    logic [15:0] fl_a, fl_b, obs_fl;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk_i(clk), .reset_i(reset_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .ex_rd_i(ex_rd_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_div_op_i(ex_div_op_i), .branch_taken_i(branch_taken_i),
        .div_done_i(div_done_i),
        .pc_write_enable_o(ctl_a[7]), .if_id_write_enable_o(ctl_a[6]), .id_ex_write_enable_o(ctl_a[5]),
        .if_id_flush_o(ctl_a[4]), .id_ex_flush_o(ctl_a[3]), .ex_mem_flush_o(ctl_a[2]),
        .div_start_o(ctl_a[1]), .div_busy_o(ctl_a[0]), .div_error_o(err_a),
        .stall_cycles_o(st_a), .flush_count_o(fl_a)
    );

    hazard_controller #(.DIV_TIMEOUT(4)) dut4 (
        .clk_i(clk), .reset_i(reset_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i), .ex_rd_i(ex_rd_i),
        .ex_mem_read_i(ex_mem_read_i), .ex_div_op_i(ex_div_op_i), .branch_taken_i(branch_taken_i),
        .div_done_i(div_done_i),
        .pc_write_enable_o(ctl_b[7]), .if_id_write_enable_o(ctl_b[6]), .id_ex_write_enable_o(ctl_b[5]),
        .if_id_flush_o(ctl_b[4]), .id_ex_flush_o(ctl_b[3]), .ex_mem_flush_o(ctl_b[2]),
        .div_start_o(ctl_b[1]), .div_busy_o(ctl_b[0]), .div_error_o(err_b),
        .stall_cycles_o(st_b), .flush_count_o(fl_b)
    );

    always_comb begin
        obs_ctl = sel ? ctl_b : ctl_a;
        obs_err = sel ? err_b : err_a;
        obs_st  = sel ? st_b : st_a;
        obs_fl  = sel ? fl_b : fl_a;
    end

    // {pc_we, if_id_we, id_ex_we, if_id_fl, id_ex_fl, ex_mem_fl, div_start, div_busy}
    localparam logic [7:0] NORM = 8'b111_000_0_0;
    localparam logic [7:0] RST  = 8'b000_111_0_0;
    localparam logic [7:0] LU   = 8'b001_010_0_0;
    localparam logic [7:0] BR   = 8'b111_110_0_0;
    localparam logic [7:0] DS   = 8'b000_001_1_0;
    localparam logic [7:0] DB   = 8'b000_001_0_1;
    localparam logic [7:0] DR   = 8'b111_000_0_1;

    typedef struct {
        string       tag;
        logic [7:0]  ctl;
        logic [31:0] st;
        logic [15:0] fl;
        logic        err;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                total++;
                if (obs_ctl !== e.ctl || obs_st !== e.st || obs_fl !== e.fl || obs_err !== e.err) begin
                    bad++;
                    $display("FAIL %s: got ctl=%b stall=%0d flush=%0d err=%b, want ctl=%b stall=%0d flush=%0d err=%b",
                             e.tag, obs_ctl, obs_st, obs_fl, obs_err, e.ctl, e.st, e.fl, e.err);
                end
            end
        end
    end

    task automatic step(input string tag, input logic [7:0] c, input logic [31:0] st,
                        input logic [15:0] fl, input logic err);
        exp_t e;
        e.tag = tag; e.ctl = c; e.st = st; e.fl = fl; e.err = err;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_rs1_i = '0; id_rs2_i = '0; ex_rd_i = '0;
        id_use_rs1_i = 0; id_use_rs2_i = 0; ex_mem_read_i = 0;
        ex_div_op_i = 0; branch_taken_i = 0; div_done_i = 0;
    endtask

    task automatic rst_pulse();
        clear_in();
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        step("rst_hold", RST, 0, 0, 0);
        reset_i = 1'b0;
    endtask

    initial begin
        clear_in();
        @(posedge clk);
        #1;
        step("reset", RST, 0, 0, 0);
        reset_i = 1'b0;
        step("idle", NORM, 0, 0, 0);

        ex_mem_read_i = 1; ex_rd_i = 5; id_rs2_i = 5; id_use_rs2_i = 1;
        step("lu_rs2", LU, 0, 0, 0);
        ex_rd_i = 0; id_rs2_i = 0;
        step("lu_x0", NORM, 1, 0, 0);
        ex_rd_i = 7; id_rs1_i = 7; id_use_rs1_i = 1; id_use_rs2_i = 0;
        step("lu_rs1", LU, 1, 0, 0);
        id_use_rs1_i = 0;
        step("lu_unused", NORM, 2, 0, 0);
        id_use_rs1_i = 1; branch_taken_i = 1;
        step("br_over_lu", BR, 2, 0, 0);
        clear_in();
        step("after_br", NORM, 2, 1, 0);

        ex_div_op_i = 1;
        step("div_start", DS, 2, 1, 0);
        branch_taken_i = 1; ex_mem_read_i = 1; ex_rd_i = 3; id_rs1_i = 3; id_use_rs1_i = 1;
        step("div_busy1", DB, 3, 1, 0);
        step("div_busy2", DB, 4, 1, 0);
        step("div_busy3", DB, 5, 1, 0);
        step("div_busy4", DB, 6, 1, 0);
        div_done_i = 1;
        step("div_done", DR, 7, 1, 0);
        clear_in();
        ex_div_op_i = 1;
        step("b2b_start", DS, 7, 1, 0);
        div_done_i = 1;
        step("b2b_done", DR, 8, 1, 0);
        ex_div_op_i = 0;
        step("done_in_run", NORM, 8, 1, 0);
        div_done_i = 0;

        ex_div_op_i = 1;
        step("abort_start", DS, 8, 1, 0);
        step("abort_busy1", DB, 9, 1, 0);
        reset_i = 1;
        step("abort_reset", RST, 10, 1, 0);
        reset_i = 0; ex_div_op_i = 0;
        step("abort_after", NORM, 0, 0, 0);

        sel = 1'b1;
        rst_pulse();
        ex_div_op_i = 1;
        step("to_start", DS, 0, 0, 0);
        step("to_busy1", DB, 1, 0, 0);
        step("to_busy2", DB, 2, 0, 0);
        step("to_busy3", DB, 3, 0, 0);
        step("to_release", DR, 4, 0, 0);
        ex_div_op_i = 0;
        step("to_err", NORM, 4, 0, 1);
        step("to_err_sticky", NORM, 4, 0, 1);
        rst_pulse();
        step("to_err_clr", NORM, 0, 0, 0);
        ex_div_op_i = 1;
        step("co_start", DS, 0, 0, 0);
        step("co_busy1", DB, 1, 0, 0);
        step("co_busy2", DB, 2, 0, 0);
        step("co_busy3", DB, 3, 0, 0);
        div_done_i = 1;
        step("co_done", DR, 4, 0, 0);
        clear_in();
        step("co_no_err", NORM, 4, 0, 0);

        sel = 1'b0;
        rst_pulse();
        branch_taken_i = 1;
        repeat (65535) begin
            @(posedge clk);
            #1;
        end
        step("sat_reach", BR, 0, 16'hFFFF, 0);
        branch_taken_i = 0;
        step("sat_hold", NORM, 0, 16'hFFFF, 0);

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
